// File: rtl/weight_mem_pkg.sv
// Shared constants, command encodings and helpers for the unified weight SRAM read path.
package weight_mem_pkg;

    localparam int AW           = 15;
    localparam int DATA_W       = 32;
    localparam int IDX_W        = 9;
    localparam int LEN_W        = 7;

    localparam int CONV_WPK     = 13;
    localparam int W1_WPC       = 24;
    localparam int W2_WPC       = 96;
    localparam int W2_BASE      = 9216;

    localparam int CONV_KERNELS = 96;
    localparam int W1_COLS      = 384;
    localparam int W2_COLS      = 96;

    typedef enum logic [1:0] {
        CONV = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        RSVD = 2'd3
    } fetch_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  idx;
        logic              last;
    } fetch_word_t;

    function automatic logic cmd_is_legal(input fetch_mode_e mode, input logic [IDX_W-1:0] index);
        case (mode)
            CONV:    return int'(index) < CONV_KERNELS;
            W1:      return int'(index) < W1_COLS;
            W2:      return int'(index) < W2_COLS;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] burst_len(input fetch_mode_e mode);
        case (mode)
            CONV:    return LEN_W'(CONV_WPK);
            W1:      return LEN_W'(W1_WPC);
            W2:      return LEN_W'(W2_WPC);
            default: return '0;
        endcase
    endfunction

    // Every legal product fits in AW bits; the top of W2 lands on word 18431.
    function automatic logic [AW-1:0] burst_base(input fetch_mode_e mode, input logic [IDX_W-1:0] index);
        logic [AW-1:0] idx_ext;
        idx_ext = AW'(index);
        case (mode)
            CONV:    return idx_ext * AW'(CONV_WPK);
            W1:      return idx_ext * AW'(W1_WPC);
            W2:      return AW'(W2_BASE) + idx_ext * AW'(W2_WPC);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry skid FIFO carrying a weight word with its burst offset and last flag.
module weight_skid_fifo
    import weight_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fetch_word_t push_word,
    input  logic        pop,
    output fetch_word_t head,
    output logic [1:0]  count
);

    fetch_word_t entry0;
    fetch_word_t entry1;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = entry0;

    // entry0 is always the head, so the output only moves on a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= push_word;
                    end else begin
                        entry1 <= push_word;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= push_word;
                    end else begin
                        entry0 <= push_word;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Weight SRAM read sequencer: turns one fetch command into a burst of single-word reads
// and streams the returned words to the requesting buffer through a 2-entry skid FIFO.
module weight_fetch_sequencer
    import weight_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [IDX_W-1:0]  cmd_index,
    output logic              cmd_err,
    output logic [AW-1:0]     mem_rd_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_word_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    fetch_state_e     state;
    fetch_mode_e      req_mode;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] inflight_idx;
    logic             inflight;
    logic             inflight_last;
    logic             cmd_fire;
    logic             cmd_legal;
    logic             issue_last;
    logic             pop;
    logic [1:0]       fifo_count;
    logic [2:0]       occupancy;
    fetch_word_t      push_word;
    fetch_word_t      head_word;

    assign req_mode   = fetch_mode_e'(cmd_mode);
    assign cmd_legal  = cmd_is_legal(req_mode, cmd_index);
    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign pop        = out_valid && out_ready;
    assign issue_last = (issued == len_m1);

    // Words that will sit in FIFO plus in flight next cycle before any new read;
    // a read is only launched while that leaves room for it.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign mem_rd_en  = (state == ST_ISSUE) && (occupancy < 3'd2);

    assign push_word  = {mem_rd_data, inflight_idx, inflight_last};
    assign out_valid  = (fifo_count != 2'd0);
    assign out_data     = head_word.data;
    assign out_word_idx = head_word.idx;
    assign out_last     = head_word.last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mem_rd_addr   <= '0;
            issued        <= '0;
            len_m1        <= '0;
            inflight      <= 1'b0;
            inflight_idx  <= '0;
            inflight_last <= 1'b0;
            cmd_err       <= 1'b0;
            done          <= 1'b0;
        end else begin
            cmd_err       <= 1'b0;
            done          <= 1'b0;
            inflight      <= mem_rd_en;
            inflight_idx  <= issued;
            inflight_last <= issue_last;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_legal) begin
                            state       <= ST_ISSUE;
                            mem_rd_addr <= burst_base(req_mode, cmd_index);
                            issued      <= '0;
                            len_m1      <= burst_len(req_mode) - LEN_W'(1);
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_rd_en) begin
                        mem_rd_addr <= mem_rd_addr + AW'(1);
                        issued      <= issued + LEN_W'(1);
                        if (issue_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Linger one cycle with done high so cmd_ready returns after it.
                    if (done) begin
                        state <= ST_IDLE;
                    end else if (pop && out_last) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    weight_skid_fifo u_skid_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_word (push_word),
        .pop       (pop),
        .head      (head_word),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Self-checking bench: directed timing cases plus random commands under random backpressure,
// scored against a queue-based model of the expected read addresses and streamed words.
module tb_weight_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'd0;
    logic [8:0]  cmd_index = 9'd0;
    logic        cmd_err;
    logic [14:0] mem_rd_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [6:0]  out_word_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd0 = 0;
    int readyMode = 0;
    int firstRd = -1, lastRd = -1, firstOut = -1, lastOut = -1, doneRel = -1, outCount = 0;
    int readsSeen = 0, handsSeen = 0;
    int doneCnt = 0, errCnt = 0, expDone = 0, expErr = 0;
    bit prevStall = 1'b0;
    logic [39:0] prevPayload = '0;
    int addrQ[$];
    logic [39:0] wordQ[$];

    weight_fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_index    (cmd_index),
        .cmd_err      (cmd_err),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_word_idx (out_word_idx),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h13570000;
    endfunction

    // Memory model: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= memword(int'(mem_rd_addr));
        else           mem_rd_data <= $urandom;
    end

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(((cyc - cmd0) >= 5) && ((cyc - cmd0) <= 9));
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        logic [39:0] got;
        rel = cyc - cmd0;
        got = {out_data, out_word_idx, out_last};
        if (!rst) begin
            checkOutput("occupancy_le2", (readsSeen - handsSeen) <= 2, 1);
            if (prevStall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_payload", got, prevPayload);
            end
            if (out_valid) checkOutput("valid_expected", wordQ.size() != 0, 1);
            if (mem_rd_en) begin
                checkOutput("rd_expected", addrQ.size() != 0, 1);
                if (addrQ.size() != 0) checkOutput("rd_addr", mem_rd_addr, addrQ.pop_front());
                if (firstRd < 0) firstRd = rel;
                lastRd = rel;
                readsSeen++;
            end
            if (out_valid && out_ready) begin
                if (wordQ.size() != 0) checkOutput("out_word", got, wordQ.pop_front());
                if (firstOut < 0) firstOut = rel;
                lastOut = rel;
                outCount++;
                handsSeen++;
            end
            if (done) begin
                doneCnt++;
                doneRel = rel;
            end
            if (cmd_err) errCnt++;
            prevStall   = out_valid && !out_ready;
            prevPayload = got;
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
        checkOutput({tag, "_cmd_err"}, cmd_err, 0);
        checkOutput({tag, "_rd_addr"}, mem_rd_addr, 0);
        checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_word_idx"}, out_word_idx, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [8:0] index, input bit waitDone);
        int len, base, n;
        bit legal;
        legal = (mode != 2'd3) && (int'(index) < ((mode == 2'd1) ? 384 : 96));
        len   = (mode == 2'd0) ? 13 : (mode == 2'd1) ? 24 : 96;
        base  = ((mode == 2'd2) ? 9216 : 0) + int'(index) * len;
        @(negedge clk);
        cmd_mode  = mode;
        cmd_index = index;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready_seen", cmd_ready, 1);
        cmd0 = cyc;
        firstRd = -1; lastRd = -1; firstOut = -1; lastOut = -1; doneRel = -1; outCount = 0;
        if (legal) begin
            for (int i = 0; i < len; i++) begin
                addrQ.push_back(base + i);
                wordQ.push_back({memword(base + i), 7'(i), (i == len - 1)});
            end
        end
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!legal) begin
            expErr++;
            checkOutput("err_pulse", cmd_err, 1);
            checkOutput("err_cmd_ready", cmd_ready, 1);
            checkOutput("err_busy", busy, 0);
            @(negedge clk);
            #1;
            checkOutput("err_clear", cmd_err, 0);
            checkOutput("err_still_ready", cmd_ready, 1);
        end else if (waitDone) begin
            n = 0;
            while (doneRel < 0 && n < 3000) begin
                @(negedge clk);
                #1;
                n++;
            end
            checkOutput("done_seen", doneRel >= 0, 1);
            checkOutput("burst_words", outCount, len);
            checkOutput("busy_at_done", busy, 1);
            @(negedge clk);
            #1;
            checkOutput("ready_after_done", cmd_ready, 1);
            expDone++;
        end
    endtask

    task automatic checkFullSpeedTiming(input string tag, input int len);
        checkOutput({tag, "_first_rd"}, firstRd, 1);
        checkOutput({tag, "_last_rd"}, lastRd, len);
        checkOutput({tag, "_first_out"}, firstOut, 3);
        checkOutput({tag, "_last_out"}, lastOut, len + 2);
        checkOutput({tag, "_done_cycle"}, doneRel, len + 3);
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit found;
        logic [1:0] m;
        logic [8:0] idx;

        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("rst_init");
        rst = 1'b0;

        $display("[TB] CONV kernel 5 at full speed");
        readyMode = 0;
        applyStimulus(2'd0, 9'd5, 1'b1);
        checkFullSpeedTiming("conv5", 13);

        $display("[TB] W2 column 95 at full speed");
        applyStimulus(2'd2, 9'd95, 1'b1);
        checkFullSpeedTiming("w2_95", 96);

        $display("[TB] W1 column 10 with a backpressure window");
        readyMode = 2;
        applyStimulus(2'd1, 9'd10, 1'b1);
        readyMode = 0;

        $display("[TB] Illegal commands");
        applyStimulus(2'd1, 9'd384, 1'b0);
        applyStimulus(2'd3, 9'd0, 1'b0);

        $display("[TB] Reset in the middle of a W1 burst");
        applyStimulus(2'd1, 9'd200, 1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            #1;
            if (out_valid && out_word_idx == 7'd7) found = 1'b1;
            n++;
        end
        checkOutput("rst_word7_seen", found, 1);
        rst = 1'b1;
        addrQ.delete();
        wordQ.delete();
        readsSeen = 0;
        handsSeen = 0;
        prevStall = 1'b0;
        @(negedge clk);
        #1;
        checkResetOutputs("rst_mid");
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            checkOutput("rst_no_valid", out_valid, 0);
        end
        applyStimulus(2'd0, 9'd0, 1'b1);
        checkFullSpeedTiming("conv0", 13);

        $display("[TB] Random legal commands under random backpressure");
        readyMode = 1;
        for (int k = 0; k < 50; k++) begin
            m   = 2'($urandom_range(0, 2));
            idx = 9'((m == 2'd1) ? $urandom_range(0, 383) : $urandom_range(0, 95));
            applyStimulus(m, idx, 1'b1);
        end
        readyMode = 0;
        repeat (4) @(negedge clk);
        #1;

        checkOutput("done_count", doneCnt, expDone);
        checkOutput("err_count", errCnt, expErr);
        checkOutput("addr_queue_empty", addrQ.size(), 0);
        checkOutput("word_queue_empty", wordQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fetch_sequencer.md
# weight_fetch_sequencer

Read-side sequencer for the unified weight SRAM. It accepts one fetch command at a time from the active engine controller: a Conv kernel, an MLP W1 column or an MLP W2 column. It converts the command into a burst of single-word reads and streams the returned words to the requesting weight buffer over a valid/ready interface. It sits between the controllers (via the DSU) and the weight memory read port, and hides the memory's 1-cycle read latency behind a 2-entry skid FIFO.

## Interface
- `AW`, 15, weight memory address width
- `CONV_WPK`, 13, words per Conv kernel (12 PE words + 1 bias)
- `W1_WPC`, 24, words per W1 column
- `W2_WPC`, 96, words per W2 column
- `W2_BASE`, 9216, first word address of W2
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE; reset 1
- `cmd_mode`  in  2  0=CONV, 1=W1, 2=W2, 3=reserved
- `cmd_index`  in  9  kernel (0..95), W1 col (0..383), W2 col (0..95)
- `cmd_err`  out  1  1-cycle pulse on an illegal command; reset 0
- `mem_rd_addr`  out  AW  read address; reset 0
- `mem_rd_en`  out  1  read strobe; reset 0
- `mem_rd_data`  in  32  valid the cycle after `mem_rd_en`
- `out_valid`  out  1  stream word valid; reset 0
- `out_ready`  in  1  consumer ready
- `out_data`  out  32  weight word; reset 0
- `out_word_idx`  out  7  offset of the word within the burst (0..len-1); reset 0
- `out_last`  out  1  set on the final word of the burst; reset 0
- `busy`  out  1  high from the cycle after accept through the `done` cycle; reset 0
- `done`  out  1  1-cycle pulse after the last word handshake; reset 0

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `cmd_ready`=1; accept when `cmd_valid`.
  - Base and length per mode:
    - CONV: base = index×13, len = 13
    - W1: base = index×24, len = 24
    - W2: base = W2_BASE + index×96, len = 96
  - Multiplies are computed at AW width with no overflow; the maximum address is 18431.
  - Illegal command (mode 3, or index ≥ 96/384/96 for CONV/W1/W2): accept it, pulse `cmd_err`, issue no reads, stay in IDLE, no `done` pulse.
- **ISSUE**
  - Assert `mem_rd_en` with `mem_rd_addr` = base + issued_count.
  - Issue only when fifo_count + inflight − pop < 2, where pop = `out_valid` & `out_ready` in the current cycle.
  - When issued_count reaches len, go to DRAIN.
- **DRAIN**
  - No reads are issued.
  - When the handshake on the `out_last` word occurs, pulse `done` next cycle and return to IDLE.
- inflight is a 1-bit flag: set on `mem_rd_en`, cleared the next cycle when `mem_rd_data` is pushed into the FIFO.
- FIFO push and pop can occur in the same cycle; the count stays the same.
- `out_word_idx` and `out_last` are stored alongside each word in the FIFO, so they remain correct under backpressure.
- `out_data` and the other FIFO outputs hold stable while `out_valid` & !`out_ready`.
- Reset mid-burst:
  - All state returns to IDLE, the FIFO is flushed and inflight is cleared.
  - Memory data returning in the cycle after reset is discarded.
  - No `done` or `cmd_err` pulse.

## Timing
- Cmd handshake in cycle 0 → `mem_rd_en` with the first address in cycle 1 → data captured in cycle 2 → `out_valid` in cycle 3.
- With `out_ready` held at 1, throughput is one word per cycle: a CONV burst delivers words in cycles 3..15 and `done` pulses in cycle 16.
- `cmd_ready` reasserts in the cycle after `done`. Back-to-back commands are therefore separated by at least one IDLE cycle.
- Never more than 2 words held in FIFO plus in flight, under any `out_ready` pattern.
- `cmd_err` pulses in cycle 1 for an illegal command accepted in cycle 0.

## Structure
- Shared package `weight_mem_pkg`:
  - `fetch_mode_e` enum (CONV, W1, W2, RSVD)
  - CONV_WPK, W1_WPC, W2_WPC, W2_BASE, CONV_KERNELS=96, W1_COLS=384, W2_COLS=96
  - weight memory AW=15
- Sub-module `weight_skid_fifo`: 2-entry, 40-bit payload (data + idx + last), synchronous active-high `rst`, count output.

## Test plan
- CONV k=5, `out_ready`=1 → `mem_rd_addr` 65..77 in cycles 1..13; 13 words with idx 0..12; `out_last` on idx 12; `done` in cycle 16.
- W2 col 95, `out_ready`=1 → addresses 18336..18431; 96 words; no gaps after cycle 3.
- W1 col 10 with `out_ready` low for cycles 5..9 → addresses 240..263; FIFO+inflight ≤ 2 throughout; all 24 words delivered in order, with no loss or duplicate; `out_data` stable while stalled.
- Illegal commands (W1 index 384; mode 3) → `cmd_err` pulses in cycle 1, no `mem_rd_en`, no `done`, `cmd_ready` stays 1.
- Assert `rst` for 1 cycle at word 7 of a W1 burst → outputs at reset values the next cycle, no further `out_valid`. A new CONV k=0 command then fetches addresses 0..12 correctly.
- Random `out_ready` over 50 random legal commands → scoreboard against a memory model: exact address sequence, word order and `done` count.
